uart_display_feeder: RTL
========================

Name: uart_display_feeder

Overview:
- Upstream stage of the seven-segment controller. Supplies its four display bytes (seg87..seg21) and its per-digit refresh strobe (clock_enable).
- Snoops the UART TX byte handshake and keeps a history of the last four transmitted bytes plus a 16-bit sent-byte counter.
- Composes a registered 32-bit display word according to a mode select, with freeze and clear controls.

Parameters:
- REFRESH_DIV, 100000, system_clock cycles per clock_enable pulse (digit-advance rate); legal range 2..2^24.
- CNT_W, 16, width of sent-byte counter; fixed at 16 for display mapping.

Ports:
- system_clock  input  1  single clock, all logic rising-edge.
- cpu_rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  UART TX byte offered.
- tx_ready  input  1  UART TX accepting; a byte is accepted when tx_valid && tx_ready.
- tx_data  input  8  byte being transmitted.
- mode  input  1  0 = HISTORY, 1 = COUNT.
- freeze  input  1  1 = hold the displayed word.
- clear  input  1  synchronous clear of history, counter and wrap flag.
- seg87  output  8  display byte, leftmost two digits.
- seg65  output  8  display byte.
- seg43  output  8  display byte.
- seg21  output  8  display byte, rightmost two digits.
- clock_enable  output  1  one-cycle refresh strobe to the display controller.
- cnt_wrap  output  1  sticky flag: sent-byte counter wrapped.

Behaviour:
- Reset (cpu_rst_n low, async): history, counter, display word, refresh counter, clock_enable and cnt_wrap all 0. All seg outputs read 0x00.
- Refresh tick:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - clock_enable=1 for exactly the one cycle in which div_cnt==REFRESH_DIV-1, otherwise 0.
  - First pulse occurs REFRESH_DIV cycles after reset release.
  - Free-running; not affected by clear, freeze or mode.
- Accept event: acc = tx_valid && tx_ready && !clear.
  - On acc, hist[31:0] <= {hist[23:0], tx_data}; hist[7:0] is the newest byte, hist[31:24] the oldest.
  - On acc, byte_cnt <= byte_cnt+1, modulo 2^16. On transition 0xFFFF->0x0000, cnt_wrap <= 1.
  - tx_valid without tx_ready: no capture; a held byte is captured once, on the handshake cycle only.
- Clear (synchronous): hist <= 0, byte_cnt <= 0, cnt_wrap <= 0. Clear wins over a simultaneous accept: that byte is neither stored nor counted.
- Composition (combinational from the current registers):
  - HISTORY: word = hist.
  - COUNT: word = {byte_cnt[15:0], hist[15:0]}, i.e. count on seg87/seg65 and the last two bytes on seg43/seg21.
- Display register:
  - freeze=0: disp <= word every cycle. Outputs lag the history/counter update by 1 cycle, so an accept at edge N is visible after edge N+1.
  - freeze=1: disp holds. Capture and counting continue underneath.
  - On freeze deassert, disp updates at the next edge to the current word, with no replay of intermediate values.
  - mode change while unfrozen takes effect after 1 cycle.
- Clear while frozen: internal state clears, but the display still holds the old value until unfreeze.
- Reset mid-operation: everything returns to the reset values immediately; the tick phase restarts at 0.

Decomposition:
- display_pkg:
  - typedef enum logic {MODE_HISTORY=1'b0, MODE_COUNT=1'b1} disp_mode_t
  - localparam DISP_W=32
  - localparam DEFAULT_REFRESH_DIV=100000
- Sub-module refresh_tick_gen (parameter REFRESH_DIV; ports system_clock, cpu_rst_n, tick). Reusable elsewhere for other prescaled strobes.
- History, counter and display register stay in the top module.

Test Plan (bench uses REFRESH_DIV=4):
- Release reset, idle 12 cycles -> seg all 0x00; clock_enable pulses at cycles 4, 8, 12 after release, each 1 cycle wide.
- HISTORY: accept 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> seg87..seg21 = 0x22, 0x33, 0x44, 0x55, one cycle after the last accept. tx_valid held 3 cycles with tx_ready low then high for 1 cycle -> exactly one capture.
- COUNT: after 0x12A accepts ending in 0xAB, 0xCD -> seg87=0x01, seg65=0x2A, seg43=0xAB, seg21=0xCD. Force the counter to 0xFFFF, then one accept -> count 0x0000 and cnt_wrap=1.
- Freeze: display 0xDEADBEEF, freeze=1, accept 0x01, 0x02 -> outputs stay 0xDEADBEEF. freeze=0 -> next cycle shows 0xBEEF0102.
- Clear with a simultaneous accept of 0x99 -> history 0, count 0, cnt_wrap 0; 0x99 absent; outputs 0x00000000 one cycle later.
- Assert cpu_rst_n low asynchronously mid-tick-period with non-zero history -> outputs 0 without a clock edge; the first clock_enable arrives 4 cycles after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the UART display feeder and its helpers.
package display_pkg;

  // What the display word shows: the raw byte history, or the count plus the last two bytes
  typedef enum logic {
    MODE_HISTORY = 1'b0,
    MODE_COUNT   = 1'b1
  } disp_mode_t;

  localparam int DISP_W              = 32;
  localparam int DEFAULT_REFRESH_DIV = 100000;

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running prescaler that emits a one-cycle strobe every REFRESH_DIV clocks.
// The strobe is high while the phase counter sits at its last value, so the
// first strobe appears REFRESH_DIV cycles after reset release.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic system_clock,
  input  logic cpu_rst_n,
  output logic tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Phase counter: 0..REFRESH_DIV-1, then back to 0
  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_display_feeder.sv
// Snoops the UART TX handshake, keeps the last four bytes and a sent-byte
// count, and feeds a registered 32-bit word plus a refresh strobe to the
// seven-segment controller.
module uart_display_feeder
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int CNT_W       = 16
) (
  input  logic       system_clock,
  input  logic       cpu_rst_n,
  input  logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       mode,
  input  logic       freeze,
  input  logic       clear,
  output logic [7:0] seg87,
  output logic [7:0] seg65,
  output logic [7:0] seg43,
  output logic [7:0] seg21,
  output logic       clock_enable,
  output logic       cnt_wrap
);

  logic [DISP_W-1:0] hist;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DISP_W-1:0] word;
  logic [DISP_W-1:0] disp;
  logic              acc;
  disp_mode_t        disp_mode;

  refresh_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .system_clock (system_clock),
    .cpu_rst_n    (cpu_rst_n),
    .tick         (clock_enable)
  );

  // A byte is taken only on the handshake cycle; clear suppresses it entirely
  assign acc       = tx_valid && tx_ready && !clear;
  assign disp_mode = disp_mode_t'(mode);

  // History shift register, sent-byte counter and sticky wrap flag
  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      hist     <= '0;
      byte_cnt <= '0;
      cnt_wrap <= 1'b0;
    end else if (clear) begin
      hist     <= '0;
      byte_cnt <= '0;
      cnt_wrap <= 1'b0;
    end else if (acc) begin
      hist     <= {hist[DISP_W-9:0], tx_data};
      byte_cnt <= byte_cnt + CNT_W'(1);
      if (byte_cnt == '1) begin
        cnt_wrap <= 1'b1;
      end
    end
  end

  // Select what the display should show from the current state
  always_comb begin
    word = hist;
    if (disp_mode == MODE_COUNT) begin
      word = {byte_cnt, hist[15:0]};
    end
  end

  // Display register: follows the composed word unless frozen
  always_ff @(posedge system_clock or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      disp <= '0;
    end else if (!freeze) begin
      disp <= word;
    end
  end

  assign seg87 = disp[31:24];
  assign seg65 = disp[23:16];
  assign seg43 = disp[15:8];
  assign seg21 = disp[7:0];

endmodule
